// File: rtl/interpreter_receiver_if.sv
// Link between the processor-side strobe/data source, the receiver, and the interpreter consumer.
// The master modport belongs to the environment (source and consumer). The slave modport belongs to the receiver.
interface interpreter_receiver_if #(
    parameter int unsigned DATA_W = 15,
    parameter int unsigned DEPTH  = 8
);
    logic                     strobe_in;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        word_out;
    logic                     word_valid;
    logic                     word_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output strobe_in, data_in, word_ready,
        input  word_out, word_valid, count, overflow
    );

    modport slave (
        input  strobe_in, data_in, word_ready,
        output word_out, word_valid, count, overflow
    );
endinterface

// File: rtl/interpreter_receiver.sv
// Interpreter-side receiver: synchronizes the processor strobe and captures one word per strobe rise.
// Captured words go into a show-ahead FIFO that is read through a valid/ready handshake.
module interpreter_receiver #(
    parameter int unsigned DATA_W      = 15,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  reset,
    interpreter_receiver_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   prev_q;
    logic                   armed_q, armed_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic s_sync, rise, valid, full, pop, push;

    // fill_q marks chain stages that hold a post-reset sample, so the reset-cleared
    // zeros cannot arm the detector while the strobe is actually still high.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.strobe_in};
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign s_sync  = sync_q[SYNC_STAGES-1];
    assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s_sync);
    assign rise    = s_sync & ~prev_q & armed_q;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid & bus.word_ready;
    assign push  = rise & (~full | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        overflow_d = overflow_q | (rise & full & ~pop);
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            fill_q     <= '0;
            prev_q     <= 1'b0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            fill_q     <= fill_d;
            prev_q     <= s_sync;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.word_valid = valid;
    assign bus.word_out   = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_interpreter_receiver.sv
// Self-checking bench for interpreter_receiver: a vector table, directed corner sequences,
// and a randomized run, all compared against a queue-based reference model.
module tb_interpreter_receiver;
    localparam int DW    = 15;
    localparam int DEPTH = 8;
    localparam int SS    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interpreter_receiver_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    interpreter_receiver #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Reference model: a word is captured SS edges after the first edge that sees the
    // strobe high, provided the previous edge saw it low outside reset.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            pend;
    logic [DW-1:0] pend_d;
    bit            low_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit full_now;
        bit pop_now;
        if (reset) begin
            mq.delete();
            m_ovf  = 1'b0;
            pend   = 0;
            low_ok = 1'b0;
        end else begin
            full_now = (mq.size() == DEPTH);
            pop_now  = bus.word_ready && (mq.size() > 0);
            if (pop_now) void'(mq.pop_front());
            if (pend == 1) begin
                if (!full_now || pop_now) mq.push_back(pend_d);
                else m_ovf = 1'b1;
            end
            if (pend > 0) pend--;
            if (bus.strobe_in && low_ok) begin
                pend   = SS;
                pend_d = bus.data_in;
            end
            low_ok = !bus.strobe_in;
        end
    endtask

    task automatic model_check();
        logic [DW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("m_count", 32'(bus.count), 32'(mq.size()));
        chk("m_valid", 32'(bus.word_valid), 32'(mq.size() != 0));
        chk("m_word",  32'(bus.word_out), 32'(head));
        chk("m_ovf",   32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        bus.strobe_in = 1'b1;
        bus.data_in   = d;
        repeat (5) cyc();
        bus.strobe_in = 1'b0;
        repeat (5) cyc();
    endtask

    logic [DW-1:0] exp_q[$];

    task automatic drain(input string nm);
        bus.word_ready = 1'b1;
        foreach (exp_q[i]) begin
            chk({nm, "_valid"}, 32'(bus.word_valid), 32'd1);
            chk({nm, "_word"},  32'(bus.word_out),   32'(exp_q[i]));
            cyc();
        end
        bus.word_ready = 1'b0;
        chk({nm, "_empty"}, 32'(bus.word_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.strobe_in = 1'b0;
        bus.word_ready = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (5) cyc();
    endtask

    typedef struct {
        logic          rst;
        logic          s;
        logic [DW-1:0] d;
        logic          rdy;
        logic          v;
        logic [DW-1:0] o;
        logic [3:0]    c;
        logic          ov;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic s, input logic [DW-1:0] d,
                                input logic rdy, input logic v, input logic [DW-1:0] o,
                                input logic [3:0] c, input logic ov);
        vec_t r;
        r.rst = rst; r.s = s; r.d = d; r.rdy = rdy;
        r.v = v; r.o = o; r.c = c; r.ov = ov;
        return r;
    endfunction

    vec_t tbl[15];

    initial begin
        reset          = 1'b1;
        bus.strobe_in  = 1'b0;
        bus.data_in    = '0;
        bus.word_ready = 1'b0;

        // Single transfer: strobe high 6 cycles, word visible after the third high edge.
        tbl[0]  = mk(1'b1, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234, 4'd1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234, 4'd1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234, 4'd1, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234, 4'd1, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 15'h1234, 1'b1, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 15'h0,    1'b1, 1'b0, 15'h0,    4'd0, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 15'h0,    1'b0, 1'b0, 15'h0,    4'd0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            reset          = tbl[i].rst;
            bus.strobe_in  = tbl[i].s;
            bus.data_in    = tbl[i].d;
            bus.word_ready = tbl[i].rdy;
            cyc();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.word_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_word", i),  32'(bus.word_out),   32'(tbl[i].o));
            chk($sformatf("tbl%0d_count", i), 32'(bus.count),      32'(tbl[i].c));
            chk($sformatf("tbl%0d_ovf", i),   32'(bus.overflow),   32'(tbl[i].ov));
        end

        // Burst and order.
        do_reset();
        for (int i = 1; i <= 8; i++) pulse(DW'(i));
        chk("burst_count", 32'(bus.count), 32'd8);
        exp_q = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8};
        drain("burst");
        chk("burst_ovf", 32'(bus.overflow), 32'd0);

        // Overflow while full: the extra word is dropped, order preserved.
        for (int i = 1; i <= 8; i++) pulse(DW'(i + 16));
        pulse(15'h7FFF);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count),    32'd8);
        chk("ovf_head",  32'(bus.word_out), 32'h11);
        exp_q = '{15'h11, 15'h12, 15'h13, 15'h14, 15'h15, 15'h16, 15'h17, 15'h18};
        drain("ovf_drain");
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Simultaneous push and pop while full.
        do_reset();
        for (int i = 1; i <= 8; i++) pulse(DW'(i));
        bus.strobe_in = 1'b1;
        bus.data_in   = 15'h0ABC;
        repeat (2) cyc();
        bus.word_ready = 1'b1;
        cyc();
        bus.word_ready = 1'b0;
        chk("pp_count", 32'(bus.count),    32'd8);
        chk("pp_ovf",   32'(bus.overflow), 32'd0);
        repeat (2) cyc();
        bus.strobe_in = 1'b0;
        repeat (5) cyc();
        exp_q = '{15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8, 15'h0ABC};
        drain("pp_drain");

        // Strobe held high across reset release.
        reset         = 1'b1;
        bus.strobe_in = 1'b1;
        bus.data_in   = 15'h0077;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (6) cyc();
        chk("hold_nocap", 32'(bus.count), 32'd0);
        bus.strobe_in = 1'b0;
        repeat (5) cyc();
        pulse(15'h0042);
        chk("hold_count", 32'(bus.count), 32'd1);
        exp_q = '{15'h0042};
        drain("hold_drain");

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) pulse(DW'(15'h100 + i));
        chk("mid_pre", 32'(bus.count), 32'd3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_count", 32'(bus.count),      32'd0);
        chk("mid_valid", 32'(bus.word_valid), 32'd0);
        chk("mid_ovf",   32'(bus.overflow),   32'd0);
        repeat (4) cyc();
        pulse(15'h0005);
        exp_q = '{15'h0005};
        drain("mid_drain");

        // Randomized traffic checked against the model on every cycle.
        for (int p = 0; p < 40; p++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(8, 4));
            lo = int'($urandom_range(8, 4));
            bus.strobe_in = 1'b1;
            bus.data_in   = DW'($urandom);
            for (int k = 0; k < hi; k++) begin
                bus.word_ready = ($urandom_range(3, 0) == 0);
                cyc();
            end
            bus.strobe_in = 1'b0;
            for (int k = 0; k < lo; k++) begin
                bus.word_ready = ($urandom_range(3, 0) == 0);
                reset = (k == 1) && ($urandom_range(14, 0) == 0);
                cyc();
            end
            reset = 1'b0;
            repeat (2) cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
